// File: rtl/s2p_link_scheduler.sv
// s2p_link_scheduler: round-robin sharing of one serial_to_parallel deserializer among R word requesters
module s2p_link_scheduler #(
  parameter int N = 8,
  parameter int R = 4,
  parameter int TIMEOUT = 16,
  localparam int ID_W = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [R-1:0]    req,
  input  logic [R*N-1:0]  req_data,
  output logic [R-1:0]    ack,
  output logic            s2p_reset,
  output logic            s2p_data_in,
  input  logic            s2p_full_tick,
  input  logic [N-1:0]    s2p_data_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [ID_W-1:0] out_id,
  output logic            out_mismatch,
  output logic            out_timeout
);
  localparam int BW = $clog2(N + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, WAIT_TICK, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, out_id_q, out_id_d, gnt;
  logic [N-1:0] shreg_q, shreg_d, sent_q, sent_d, out_data_q, out_data_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [R-1:0] ack_q, ack_d;
  logic s2p_reset_q, s2p_reset_d, data_in_q, data_in_d, out_valid_q, out_valid_d;
  logic mism_q, mism_d, tmo_q, tmo_d, found;
  logic [ID_W:0] idx;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < R; k++) begin
      idx = (ID_W+1)'(rr_q) + (ID_W+1)'(k);
      idx = (idx >= (ID_W+1)'(R)) ? idx - (ID_W+1)'(R) : idx;
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        gnt = idx[ID_W-1:0];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    shreg_d = shreg_q;
    sent_d = sent_q;
    bit_cnt_d = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_id_d = out_id_q;
    mism_d = mism_q;
    tmo_d = tmo_q;
    ack_d = '0;
    s2p_reset_d = 1'b0;
    data_in_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        shreg_d = req_data[gnt*N +: N];
        sent_d = req_data[gnt*N +: N];
        id_d = gnt;
        ack_d = R'(1) << gnt;
        rr_d = (gnt == ID_W'(R - 1)) ? '0 : gnt + 1'b1;
        s2p_reset_d = 1'b1;
        state_d = CLEAR;
      end
      CLEAR: begin
        data_in_d = shreg_q[0];
        shreg_d = shreg_q >> 1;
        bit_cnt_d = BW'(1);
        state_d = SHIFT;
      end
      SHIFT: if (bit_cnt_q == BW'(N)) begin
        wait_cnt_d = '0;
        state_d = WAIT_TICK;
      end else begin
        data_in_d = shreg_q[0];
        shreg_d = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      WAIT_TICK: if (s2p_full_tick || wait_cnt_q == WW'(TIMEOUT - 1)) begin
        out_data_d = s2p_full_tick ? s2p_data_out : '0;
        mism_d = s2p_full_tick && (s2p_data_out != sent_q);
        tmo_d = !s2p_full_tick;
        out_id_d = id_q;
        out_valid_d = 1'b1;
        state_d = OUTPUT;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      OUTPUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      shreg_q <= '0;
      sent_q <= '0;
      bit_cnt_q <= '0;
      wait_cnt_q <= '0;
      ack_q <= '0;
      s2p_reset_q <= 1'b1;
      data_in_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_id_q <= '0;
      mism_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      shreg_q <= shreg_d;
      sent_q <= sent_d;
      bit_cnt_q <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ack_q <= ack_d;
      s2p_reset_q <= s2p_reset_d;
      data_in_q <= data_in_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_id_q <= out_id_d;
      mism_q <= mism_d;
      tmo_q <= tmo_d;
    end
  end
  assign ack = ack_q;
  assign s2p_reset = s2p_reset_q;
  assign s2p_data_in = data_in_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_id = out_id_q;
  assign out_mismatch = mism_q;
  assign out_timeout = tmo_q;
endmodule

// File: tb/tb_s2p_link_scheduler.sv
// tb_s2p_link_scheduler: randomized scoreboard bench with a behavioural deserializer and arbiter model
module tb_s2p_link_scheduler;
  localparam int N = 8, R = 4, TIMEOUT = 16, ID_W = 2;
  logic clk = 0, reset = 1, out_ready = 1;
  logic [R-1:0] req = '0, ack;
  logic [R*N-1:0] req_data = '0;
  logic s2p_reset, s2p_data_in, s2p_full_tick = 0, out_valid, out_mismatch, out_timeout;
  logic [N-1:0] s2p_data_out, out_data;
  logic [ID_W-1:0] out_id;
  s2p_link_scheduler #(.N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .s2p_reset(s2p_reset), .s2p_data_in(s2p_data_in), .s2p_full_tick(s2p_full_tick),
    .s2p_data_out(s2p_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_mismatch(out_mismatch), .out_timeout(out_timeout)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [N-1:0] col = '0;
  int dcnt = N;
  logic kill_tick = 0, corrupt = 0;
  always @(posedge clk) begin
    if (s2p_reset === 1'b1) begin
      dcnt <= 0;
      s2p_full_tick <= 1'b0;
    end else if (dcnt < N) begin
      col[dcnt] <= s2p_data_in;
      dcnt <= dcnt + 1;
      s2p_full_tick <= !kill_tick && dcnt == N - 1;
    end else begin
      s2p_full_tick <= 1'b0;
    end
  end
  assign s2p_data_out = corrupt ? '0 : col;
  typedef struct {
    logic [ID_W-1:0] id;
    logic [N-1:0] data;
    logic mm, to;
    int ack_cyc, lat;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, ptr = 0, last_ack = -1000;
  logic [N-1:0] words[R];
  logic [N-1:0] last_word = '0;
  logic prev_ack_nz = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic raise(input int i, input logic [N-1:0] w);
    req[i] = 1'b1;
    req_data[i*N +: N] = w;
    words[i] = w;
  endtask
  task automatic step();
    int g, k;
    exp_t e;
    @(negedge clk);
    if (ack != 0) begin
      g = -1;
      for (int j = 0; j < R; j++) if (g < 0 && req[(ptr + j) % R]) g = (ptr + j) % R;
      chk("ack_grant", 32'(ack), g < 0 ? 0 : 32'(1) << g);
      chk("ack_pulse", 32'(prev_ack_nz), 0);
      chk("ack_while_valid", 32'(out_valid), 0);
      if (g >= 0) begin
        ptr = (g + 1) % R;
        req[g] = 1'b0;
        e.id = ID_W'(g);
        e.data = (kill_tick || corrupt) ? '0 : words[g];
        e.mm = !kill_tick && corrupt && words[g] != 0;
        e.to = kill_tick;
        e.ack_cyc = cyc;
        e.lat = kill_tick ? N + 1 + TIMEOUT : N + 2;
        q.push_back(e);
        last_ack = cyc;
        last_word = words[g];
      end
    end
    chk("s2p_reset", 32'(s2p_reset), 32'(ack != 0));
    k = cyc - last_ack;
    if (k >= 1 && k <= N) chk("data_in", 32'(s2p_data_in), 32'(last_word[k-1]));
    prev_ack_nz = ack != 0;
  endtask
  task automatic chk_reset();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_s2p_reset", 32'(s2p_reset), 1);
    chk("rst_data_in", 32'(s2p_data_in), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_id", 32'(out_id), 0);
    chk("rst_mismatch", 32'(out_mismatch), 0);
    chk("rst_timeout", 32'(out_timeout), 0);
  endtask
  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    @(negedge clk);
    chk_reset();
    q.delete();
    ptr = 0;
    last_ack = -1000;
    prev_ack_nz = 0;
    reset = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((req != 0 || q.size() != 0 || out_valid) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("drain_timeout", 1, 0);
  endtask
  logic pv = 0, pr = 0, pm = 0, pt = 0;
  logic [N-1:0] pd = '0;
  logic [ID_W-1:0] pi = '0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (reset) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(pd));
        chk("hold_id", 32'(out_id), 32'(pi));
        chk("hold_flags", {out_mismatch, out_timeout}, {pm, pt});
      end
      if (out_valid && !pv && q.size() != 0) chk("latency", cyc - q[0].ack_cyc, q[0].lat);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_id", 32'(out_id), 32'(e.id));
          chk("out_mismatch", 32'(out_mismatch), 32'(e.mm));
          chk("out_timeout", 32'(out_timeout), 32'(e.to));
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pi = out_id;
      pm = out_mismatch;
      pt = out_timeout;
    end
  end
  initial begin
    int acks, n, gi;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset();
    reset = 1'b0;
    raise(0, 8'hA5);
    drain();
    do_reset();
    raise(0, 8'h11); raise(1, 8'h22); raise(2, 8'h33); raise(3, 8'h44);
    acks = 0;
    n = 0;
    while (acks < 5 && n < 500) begin
      step();
      n++;
      if (ack != 0) begin
        gi = 0;
        for (int i = 0; i < R; i++) if (ack[i]) gi = i;
        chk("rr_seq", gi, rr_exp[acks]);
        acks++;
        if (acks < 5) raise(gi, words[gi]);
      end
    end
    if (acks < 5) chk("rr_timeout", acks, 5);
    drain();
    do_reset();
    raise(2, 8'h5C);
    drain();
    raise(0, 8'h01); raise(1, 8'h02);
    drain();
    out_ready = 1'b0;
    raise(3, 8'h96);
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    if (!out_valid) chk("bp_wait", 0, 1);
    repeat (10) step();
    drain();
    kill_tick = 1'b1;
    raise(1, 8'h5A);
    drain();
    kill_tick = 1'b0;
    corrupt = 1'b1;
    raise(2, 8'hFF);
    drain();
    corrupt = 1'b0;
    raise(1, 8'h3C);
    n = 0;
    while (ack == 0 && n < 50) begin step(); n++; end
    if (ack == 0) chk("mid_ack_wait", 0, 1);
    repeat (3) step();
    do_reset();
    raise(0, 8'hC3); raise(1, 8'h7E); raise(2, 8'h81); raise(3, 8'h42);
    drain();
    repeat (400) begin
      for (int i = 0; i < R; i++) if (!req[i] && $urandom_range(3) == 0) raise(i, N'($urandom));
      out_ready = $urandom_range(9) < 7;
      step();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/s2p_link_scheduler.md
Name: s2p_link_scheduler

Overview:
- Round-robin scheduler that shares one serial_to_parallel deserializer instance among R parallel-word requesters.
- For each granted word it clears the deserializer, drives the word serially onto its data_in, and waits for full_tick.
- It captures data_out, checks it against the sent word, and presents the result downstream with a valid/ready handshake.
- Sits between the requester ports and the s2p datapath, in the same environment as the s2p interface/top bench.

Parameters:
- N, 8, word width; must match the deserializer's N.
- R, 4, number of requesters, 2..16. ID_W = max(1, $clog2(R)) is a derived localparam.
- TIMEOUT, 16, maximum cycles in WAIT_TICK before aborting; must be at least 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  R  per-requester request; held high until acked.
- req_data  in  R*N  requester i's word in bits [i*N +: N].
- ack  out  R  one-hot, one-cycle pulse when a requester's word is latched.
- s2p_reset  out  1  drives the deserializer's reset input.
- s2p_data_in  out  1  serial bit to the deserializer.
- s2p_full_tick  in  1  deserializer word-complete pulse.
- s2p_data_out  in  N  deserializer parallel output.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N  captured s2p_data_out.
- out_id  out  ID_W  index of the requester that was served.
- out_mismatch  out  1  captured word differs from the sent word.
- out_timeout  out  1  no full_tick arrived within TIMEOUT cycles.

Behaviour:
- All outputs are registered.
- Reset values:
  - ack=0, s2p_reset=1, s2p_data_in=0, out_valid=0, out_data=0, out_id=0, out_mismatch=0, out_timeout=0.
  - State=IDLE, rr_ptr=0.
- Reset takes priority over everything. Mid-operation reset abandons the word in flight, produces no ack and no output for it, and sets rr_ptr=0.
- FSM states: IDLE, CLEAR, SHIFT, WAIT_TICK, OUTPUT.
- IDLE:
  - s2p_reset=0.
  - If req!=0, the winner g is the first set bit searching upward from rr_ptr, wrapping at R-1 to 0.
  - Latch req_data[g] into the shift register and the sent-word copy, latch g into the id register, pulse ack[g] for exactly the next cycle.
  - Set rr_ptr=(g+1) mod R and go to CLEAR.
- CLEAR: s2p_reset=1 for exactly one cycle, then go to SHIFT with bit_cnt=0.
- SHIFT:
  - s2p_reset=0. Each cycle s2p_data_in=shreg[0]; shreg shifts right, LSB first; bit_cnt increments.
  - After N cycles go to WAIT_TICK with wait_cnt=0.
- WAIT_TICK:
  - s2p_data_in=0.
  - If s2p_full_tick=1: capture out_data=s2p_data_out, set out_mismatch=(s2p_data_out!=sent word), out_timeout=0, go to OUTPUT.
  - Otherwise wait_cnt increments. When wait_cnt reaches TIMEOUT: out_data=0, out_mismatch=0, out_timeout=1, go to OUTPUT.
  - A full_tick arriving during CLEAR or SHIFT is ignored.
- OUTPUT:
  - out_valid=1 with out_data, out_id, out_mismatch, out_timeout held stable until out_ready=1.
  - On the ready cycle, transfer, drop out_valid next cycle and go to IDLE. No new grant is issued in that same cycle.
- Minimum word period: 1 (IDLE) + 1 (CLEAR) + N (SHIFT) + 1 or more (WAIT_TICK) + 1 or more (OUTPUT) cycles.
- Requests are sampled only in IDLE. A req that drops before grant is never served. req_data is don't-care after ack.
- rr_ptr advances only on grant, so starvation-free: with all R requesting, each is served once per R grants.

Test Plan:
- Single requester: reset, R=4, req=4'b0001, req_data[0]=8'hA5 → ack[0] pulse 1 cycle; s2p_reset high 1 cycle; s2p_data_in=1,0,1,0,0,1,0,1; out_valid with out_data=8'hA5, out_id=0, out_mismatch=0, out_timeout=0.
- Round robin: req=4'b1111 held, re-asserted after each ack, with data 8'h11/22/33/44 → out_id sequence 0,1,2,3,0; each out_data equals that requester's word.
- Pointer wrap/skip: rr_ptr=3 (after serving 2), req=4'b0011 → grant 0, then 1; requester 3 is absent and skipped.
- Backpressure: out_ready=0 for 10 cycles in OUTPUT → out_valid and all out_* stable; no ack issued; after out_ready=1, next grant occurs ≥1 cycle later.
- Timeout/mismatch: model forces s2p_full_tick=0 → out_timeout=1 exactly TIMEOUT=16 cycles after SHIFT ends, out_data=0. Model returns 8'h00 for sent 8'hFF → out_mismatch=1.
- Reset mid-SHIFT after 3 bits → all outputs at reset values next cycle; the interrupted word never appears on out_*; a fresh req is then granted starting from requester 0.
